// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Bit periods shorter than two clocks are not representable by the
    // bit counter, so every divisor is raised to at least this value.
    localparam int MIN_DIV    = 2;
    localparam int MAX_DATA_W = 9;

    // Parity over the (zero-extended) data word; odd=1 inverts even parity.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                        input logic                  odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding words waiting to be serialised.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage, wrapping pointers and occupancy; push+pop keeps count steady.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter with transmit FIFO and per-frame latched configuration.
// Line, active and done are registered from the state of the previous
// cycle, so all three outputs stay aligned with each other on the pin.
import uart_pkg::*;

module uart_tx_buffered #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_n,
    input  logic [DIV_W-1:0]              i_Div,
    input  logic                          i_Parity_En,
    input  logic                          i_Parity_Odd,
    input  logic                          i_Two_Stop,
    input  logic                          i_TX_DV,
    input  logic [DATA_W-1:0]             i_TX_Word,
    output logic                          o_TX_Ready,
    output logic                          o_TX_Drop,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
    output logic                          o_TX_Active,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Done
);

    localparam int IDX_W = $clog2(DATA_W);

    tx_state_t         state, next_state;
    logic              pop;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_dout;

    logic [DATA_W-1:0] word_l;
    logic [DIV_W-1:0]  div_l;
    logic              par_en_l, par_l, two_l;

    logic [DIV_W-1:0]  cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic              stop2;
    logic              tick, last_bit, stop_end;
    logic              line_c, done_c;

    uart_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_Clock),
        .rst_n (i_Rst_n),
        .push  (i_TX_DV),
        .din   (i_TX_Word),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_FIFO_Count)
    );

    assign o_TX_Ready = !fifo_full;

    // div_l is never below 2, so div_l-1 cannot wrap.
    assign tick     = (cnt == div_l - DIV_W'(1));
    assign last_bit = (bit_idx == IDX_W'(DATA_W-1));
    assign stop_end = tick && (!two_l || stop2);

    // State register.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next state, pop request and the line level for the current cycle.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        line_c     = 1'b1;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                line_c = 1'b0;
                if (tick) next_state = DATA;
            end
            DATA: begin
                line_c = word_l[bit_idx];
                if (tick && last_bit) next_state = par_en_l ? PARITY : STOP;
            end
            PARITY: begin
                line_c = par_l;
                if (tick) next_state = STOP;
            end
            STOP: begin
                if (stop_end) begin
                    done_c = 1'b1;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = START;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Frame datapath: config/word latch on pop, bit timer, bit index, stop half.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            word_l   <= '0;
            div_l    <= DIV_W'(MIN_DIV);
            par_en_l <= 1'b0;
            par_l    <= 1'b0;
            two_l    <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            stop2    <= 1'b0;
        end else begin
            if (pop) begin
                word_l   <= fifo_dout;
                div_l    <= (i_Div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : i_Div;
                par_en_l <= i_Parity_En;
                par_l    <= parity_bit(MAX_DATA_W'(fifo_dout), i_Parity_Odd);
                two_l    <= i_Two_Stop;
            end
            if (tick || next_state != state || state == IDLE) cnt <= '0;
            else                                               cnt <= cnt + DIV_W'(1);
            if (state != DATA) bit_idx <= '0;
            else if (tick)     bit_idx <= bit_idx + IDX_W'(1);
            if (state != STOP) stop2 <= 1'b0;
            else if (tick)     stop2 <= 1'b1;
        end
    end

    // Registered pin-side outputs.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b0;
            o_TX_Drop   <= 1'b0;
        end else begin
            o_TX_Serial <= line_c;
            o_TX_Active <= (state != IDLE);
            o_TX_Done   <= done_c;
            o_TX_Drop   <= i_TX_DV && fifo_full;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench: a queue-based frame model predicts every output on
// every cycle; directed tests add literal expectations on recorded frames.
module tb_uart_tx_buffered;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV_W      = 16;

    logic              clk = 1'b0;
    logic              rst_n, par_en, par_odd, two_stop, dv;
    logic [DIV_W-1:0]  div;
    logic [DATA_W-1:0] word;
    logic              ready, drop, active, serial, done;
    logic [$clog2(FIFO_DEPTH):0] count;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .i_Clock      (clk),
        .i_Rst_n      (rst_n),
        .i_Div        (div),
        .i_Parity_En  (par_en),
        .i_Parity_Odd (par_odd),
        .i_Two_Stop   (two_stop),
        .i_TX_DV      (dv),
        .i_TX_Word    (word),
        .o_TX_Ready   (ready),
        .o_TX_Drop    (drop),
        .o_FIFO_Count (count),
        .o_TX_Active  (active),
        .o_TX_Serial  (serial),
        .o_TX_Done    (done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic line; logic last; } ent_t;
    ent_t              lineq[$];   // pin values for the frame in flight
    logic [DATA_W-1:0] mq[$];      // words waiting in the FIFO
    int   e_serial, e_active, e_done, e_drop, e_count, e_ready;

    // recorded DUT behaviour for the directed tests
    logic line_log[$];
    int   act_cnt = 0, done_cnt = 0, drop_cnt = 0;

    task automatic add_bit(input logic b, input int n);
        for (int k = 0; k < n; k++) lineq.push_back('{line: b, last: 1'b0});
    endtask

    // A frame is start, data LSB first, optional parity, 1 or 2 stop bits.
    task automatic build_frame(input logic [DATA_W-1:0] w);
        int d;
        d = (div < 2) ? 2 : int'(div);
        add_bit(1'b0, d);
        for (int i = 0; i < DATA_W; i++) add_bit(w[i], d);
        if (par_en) add_bit(logic'(($countones(w) & 1) != 0) ^ par_odd, d);
        add_bit(1'b1, two_stop ? 2 * d : d);
        lineq[lineq.size()-1].last = 1'b1;
    endtask

    always @(posedge clk) begin
        ent_t e;
        int   pre_sz;
        bit   have;
        pre_sz = mq.size();
        if (!rst_n) begin
            mq.delete();
            lineq.delete();
            e_serial = 1; e_active = 0; e_done = 0; e_drop = 0;
        end else begin
            have = (lineq.size() > 0);
            e    = '{line: 1'b1, last: 1'b0};
            if (have) e = lineq.pop_front();
            e_serial = int'(e.line);
            e_active = int'(have);
            e_done   = int'(have && e.last);
            e_drop   = int'(dv && pre_sz == FIFO_DEPTH);
            if (lineq.size() == 0 && pre_sz > 0) build_frame(mq.pop_front());
            if (dv && pre_sz < FIFO_DEPTH) mq.push_back(word);
        end
        e_count = mq.size();
        e_ready = int'(mq.size() < FIFO_DEPTH);
        #1;
        chk("serial", int'(serial), e_serial);
        chk("active", int'(active), e_active);
        chk("done",   int'(done),   e_done);
        chk("drop",   int'(drop),   e_drop);
        chk("count",  int'(count),  e_count);
        chk("ready",  int'(ready),  e_ready);
        if (active) begin
            line_log.push_back(serial);
            act_cnt++;
        end
        if (done) done_cnt++;
        if (drop) drop_cnt++;
    end

    // ---------------- stimulus helpers (called at negedge) ----------------
    task automatic clear_rec();
        line_log.delete();
        act_cnt = 0; done_cnt = 0; drop_cnt = 0;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        dv = 1'b1; word = w;
        @(negedge clk);
        dv = 1'b0;
    endtask

    task automatic cfg(input int d, input logic pe, input logic po, input logic ts);
        div = DIV_W'(d); par_en = pe; par_odd = po; two_stop = ts;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while ((active || count != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(n >= budget), 0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] t1;
        t1 = 10'b1101001010;   // 0xA5 frame, index 0 = start bit
        rst_n = 1'b0; dv = 1'b0; word = '0;
        cfg(4, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_serial", int'(serial), 1);
        chk("rst_ready",  int'(ready),  1);
        chk("rst_drop",   int'(drop),   0);
        chk("rst_count",  int'(count),  0);
        chk("rst_active", int'(active), 0);
        chk("rst_done",   int'(done),   0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: Div=4, 8N1, 0xA5
        clear_rec();
        push_word(8'hA5);
        wait_idle(200);
        chk("t1_active_len", act_cnt, 40);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_log_len", line_log.size(), 40);
        for (int i = 0; i < 10; i++) chk("t1_bit", int'(line_log[i*4+2]), int'(t1[i]));

        // 2: Div=3, even then odd parity, two stops
        cfg(3, 1'b1, 1'b0, 1'b1);
        clear_rec();
        push_word(8'hA5);
        wait_idle(200);
        chk("t2_even_len", act_cnt, 36);
        chk("t2_even_par", int'(line_log[28]), 0);
        chk("t2_even_stop", int'(line_log[30] & line_log[35]), 1);
        cfg(3, 1'b1, 1'b1, 1'b1);
        clear_rec();
        push_word(8'hA5);
        wait_idle(200);
        chk("t2_odd_len", act_cnt, 36);
        chk("t2_odd_par", int'(line_log[28]), 1);

        // 3: six consecutive pushes, Div=2 8N1
        cfg(2, 1'b0, 1'b0, 1'b0);
        clear_rec();
        for (int i = 0; i < 6; i++) push_word(DATA_W'(8'h30 + i));
        wait_idle(400);
        chk("t3_drop_cnt", drop_cnt, 1);
        chk("t3_frames", done_cnt, 5);
        chk("t3_active_len", act_cnt, 100);
        chk("t3_stop_end", int'(line_log[19]), 1);
        chk("t3_next_start", int'(line_log[20]), 0);

        // 4: divisor change mid-frame only affects the next frame
        cfg(4, 1'b0, 1'b0, 1'b0);
        clear_rec();
        push_word(8'hA5);
        push_word(8'h01);
        repeat (10) @(negedge clk);
        div = DIV_W'(8);
        wait_idle(400);
        chk("t4_active_len", act_cnt, 120);
        chk("t4_f2_start", int'(line_log[47]), 0);
        chk("t4_f2_bit0", int'(line_log[48]), 1);

        // 5: divisors 0 and 1 behave as 2
        for (int d = 0; d < 2; d++) begin
            cfg(d, 1'b0, 1'b0, 1'b0);
            clear_rec();
            push_word(8'h55);
            wait_idle(200);
            chk("t5_len", act_cnt, 20);
            chk("t5_start", int'(line_log[1]), 0);
            chk("t5_bit0", int'(line_log[2] & line_log[3]), 1);
            chk("t5_bit1", int'(line_log[4]), 0);
        end

        // 6: reset during DATA with two words queued
        cfg(4, 1'b0, 1'b0, 1'b0);
        push_word(8'hA5);
        push_word(8'h3C);
        push_word(8'hC3);
        repeat (14) @(negedge clk);
        chk("t6_queued", int'(count), 2);
        clear_rec();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_serial", int'(serial), 1);
        chk("t6_count", int'(count), 0);
        chk("t6_active", int'(active), 0);
        repeat (100) @(negedge clk);
        chk("t6_no_done", done_cnt, 0);
        chk("t6_no_frames", act_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Parametrised UART transmitter with a built-in transmit FIFO and runtime frame configuration: data width, parity mode, stop-bit count and bit-period divisor. Replaces the single-byte fixed-format transmitter. Host logic pushes words through a ready/valid handshake, and the block serialises them back-to-back with no idle gap. It sits between USB/command logic and the board TX pin.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.
DIV_W, 16, width of the runtime bit-period divisor.

Ports:
i_Clock  in  1  system clock
i_Rst_n  in  1  synchronous reset, active low
i_Div  in  DIV_W  clocks per bit; values 0 and 1 are treated as 2
i_Parity_En  in  1  1 = append a parity bit
i_Parity_Odd  in  1  1 = odd parity, 0 = even parity
i_Two_Stop  in  1  1 = two stop bits
i_TX_DV  in  1  push strobe
i_TX_Word  in  DATA_W  word to push
o_TX_Ready  out  1  FIFO not full
o_TX_Drop  out  1  1-cycle pulse: push attempted while o_TX_Ready=0
o_FIFO_Count  out  $clog2(FIFO_DEPTH)+1  current occupancy
o_TX_Active  out  1  a frame is in progress
o_TX_Serial  out  1  serial line; idle high
o_TX_Done  out  1  1-cycle pulse at the end of each frame

Behaviour:
- Reset, synchronous: all registers and the FIFO are cleared.
  - After reset: o_TX_Serial=1, o_TX_Ready=1, o_TX_Drop=0, o_FIFO_Count=0, o_TX_Active=0, o_TX_Done=0, state IDLE.
  - Reset asserted mid-frame aborts the frame. The line is high from the next edge and queued words are discarded.
- Push:
  - A push is accepted on a rising edge where i_TX_DV=1 and o_TX_Ready=1.
  - i_TX_DV=1 with o_TX_Ready=0 leaves the FIFO unchanged and pulses o_TX_Drop on the next cycle.
  - A push and a pop in the same cycle leave the count unchanged.
- Config latch: i_Div (clamped to at least 2), i_Parity_En, i_Parity_Odd and i_Two_Stop are captured when a word is popped. Changes during a frame affect only later frames.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> (START or IDLE).
  - IDLE: line high. If the FIFO is not empty, pop the word, latch config, set o_TX_Active=1 and go to START.
  - START: line 0 for Div clocks.
  - DATA: DATA_W bits, LSB first, each held for Div clocks. The bit index runs 0..DATA_W-1.
  - PARITY: only when Parity_En is set. Bit = XOR of the data, inverted if Parity_Odd. Held for Div clocks.
  - STOP: line 1 for Div clocks (1 stop) or 2*Div clocks (2 stops). On the final clock, o_TX_Done pulses for exactly 1 cycle.
  - Leaving STOP with the FIFO non-empty: pop and go straight to START, so the start bit begins on the next clock with no idle gap and o_TX_Active stays 1.
  - Leaving STOP with the FIFO empty: go to IDLE and drop o_TX_Active.
- Latency: for a push accepted at edge N into an empty FIFO with the machine idle, the pop occurs at edge N+1 and the line goes low at edge N+2.
- Frame length = Div*(1 + DATA_W + Parity_En + 1 + Two_Stop) clocks.
- The bit counter is DIV_W wide and compares against Div-1. No wrap occurs at i_Div = 2^DIV_W - 1.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full when count = FIFO_DEPTH, empty when count = 0.

Decomposition:
- Package uart_pkg holds:
  - state encoding: IDLE, START, DATA, PARITY, STOP
  - localparam MIN_DIV = 2
  - the parity function (data, odd) -> bit
- Sub-module uart_tx_fifo: synchronous FIFO parametrised by WIDTH and DEPTH, with push/pop/full/empty/count ports, reset shared with the top level.

Test Plan:
1. Div=4, no parity, 1 stop; push 0xA5 -> line sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks, 40 clocks total; o_TX_Done pulses once; o_TX_Active is high across exactly those 40 clocks.
2. Div=3, even parity then odd parity, 2 stops; push 0xA5 -> parity bit 0 (even) and 1 (odd); stop phase is 6 clocks; frame is 36 clocks.
3. FIFO_DEPTH=4; push 5 words on consecutive cycles while idle -> first 4 words accepted (one is popped at once), 5th accepted only if o_TX_Ready=1; with 6 pushes, o_TX_Drop pulses exactly once; all accepted words go out back-to-back with no high gap between the stop bit and the next start bit.
4. Change i_Div from 4 to 8 mid-frame -> current frame stays at 4 clocks/bit; next frame uses 8.
5. i_Div=0 and i_Div=1 -> each bit lasts 2 clocks.
6. Assert i_Rst_n=0 for 1 cycle during DATA with 2 words queued -> line high on the next edge, o_FIFO_Count=0, o_TX_Active=0, no o_TX_Done pulse, no further frames sent.
